// File: rtl/pic_cpu_agent.sv
// CPU-side agent for the 8259-style interrupt controller: programs ICW1-ICW4/OCW1
// through the write port, then answers interrupt requests with an INTA pulse train.
module pic_cpu_agent #(
   parameter int PULSE_W = 2,
   parameter int GAP     = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  icw1,
   input  logic [7:0]  icw2,
   input  logic [7:0]  icw3,
   input  logic [7:0]  icw4,
   input  logic [7:0]  ocw1,
   output logic        busy,
   output logic        init_done,
   input  logic        int_i,
   input  logic        ack_en,
   output logic        cs_n,
   output logic        wr_n,
   output logic        a0,
   output logic        inta_n,
   output logic [7:0]  d_o,
   output logic        d_oe,
   input  logic [7:0]  d_i,
   output logic        vec_valid,
   output logic [15:0] vec,
   output logic        vec_err
);

   typedef enum logic [2:0] {
      IDLE, WR_SETUP, WR_LOW, WR_HOLD, WR_GAP, ACK_LOW, ACK_GAP
   } state_t;

   localparam logic [7:0] PW_LAST  = 8'(PULSE_W - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [2:0]  step;
   logic [7:0]  w_icw1, w_icw2, w_icw3, w_icw4, w_ocw1;
   logic        upm;
   logic [1:0]  pulse;
   logic [1:0]  last_pulse;
   logic [7:0]  lo_byte, hi_byte;
   logic        err_flag;
   logic [2:0]  nxt_step;
   logic [7:0]  nxt_word;

   // Step index 0..4 walks ICW1..OCW1; ICW3 is skipped in single mode, ICW4 when not requested
   always_comb begin
      nxt_step = step + 3'd1;
      if (nxt_step == 3'd2 && w_icw1[1])
         nxt_step = 3'd3;
      if (nxt_step == 3'd3 && !w_icw1[0])
         nxt_step = 3'd4;
      nxt_word = 8'h00;
      case (nxt_step)
         3'd0:    nxt_word = w_icw1;
         3'd1:    nxt_word = w_icw2;
         3'd2:    nxt_word = w_icw3;
         3'd3:    nxt_word = w_icw4;
         3'd4:    nxt_word = w_ocw1;
         default: nxt_word = 8'h00;
      endcase
   end

   assign last_pulse = upm ? 2'd1 : 2'd2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         step      <= 3'd0;
         w_icw1    <= 8'h00;
         w_icw2    <= 8'h00;
         w_icw3    <= 8'h00;
         w_icw4    <= 8'h00;
         w_ocw1    <= 8'h00;
         upm       <= 1'b0;
         pulse     <= 2'd0;
         lo_byte   <= 8'h00;
         hi_byte   <= 8'h00;
         err_flag  <= 1'b0;
         busy      <= 1'b0;
         init_done <= 1'b0;
         cs_n      <= 1'b1;
         wr_n      <= 1'b1;
         a0        <= 1'b0;
         inta_n    <= 1'b1;
         d_o       <= 8'h00;
         d_oe      <= 1'b0;
         vec_valid <= 1'b0;
         vec       <= 16'h0000;
         vec_err   <= 1'b0;
      end else begin
         vec_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  w_icw1    <= icw1;
                  w_icw2    <= icw2;
                  w_icw3    <= icw3;
                  w_icw4    <= icw4;
                  w_ocw1    <= ocw1;
                  upm       <= icw1[0] & icw4[0];
                  init_done <= 1'b0;
                  busy      <= 1'b1;
                  step      <= 3'd0;
                  cs_n      <= 1'b0;
                  a0        <= 1'b0;
                  d_o       <= icw1;
                  d_oe      <= 1'b1;
                  state     <= WR_SETUP;
               end else if (init_done && ack_en && int_i) begin
                  busy     <= 1'b1;
                  inta_n   <= 1'b0;
                  cnt      <= 8'd0;
                  pulse    <= 2'd0;
                  err_flag <= 1'b0;
                  lo_byte  <= 8'h00;
                  hi_byte  <= 8'h00;
                  state    <= ACK_LOW;
               end
            end
            WR_SETUP: begin
               wr_n  <= 1'b0;
               cnt   <= 8'd0;
               state <= WR_LOW;
            end
            WR_LOW: begin
               if (cnt == PW_LAST) begin
                  wr_n  <= 1'b1;
                  state <= WR_HOLD;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            WR_HOLD: begin
               cs_n  <= 1'b1;
               d_oe  <= 1'b0;
               cnt   <= 8'd0;
               state <= WR_GAP;
            end
            WR_GAP: begin
               if (cnt != GAP_LAST) begin
                  cnt <= cnt + 8'd1;
               end else if (step == 3'd4) begin
                  init_done <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  step  <= nxt_step;
                  a0    <= 1'b1;
                  d_o   <= nxt_word;
                  cs_n  <= 1'b0;
                  d_oe  <= 1'b1;
                  state <= WR_SETUP;
               end
            end
            // Controller data is taken on the final low cycle of each INTA pulse
            ACK_LOW: begin
               if (cnt == PW_LAST) begin
                  if (upm) begin
                     if (pulse == 2'd1)
                        lo_byte <= d_i;
                  end else begin
                     case (pulse)
                        2'd0:    err_flag <= (d_i != 8'hCD);
                        2'd1:    lo_byte  <= d_i;
                        default: hi_byte  <= d_i;
                     endcase
                  end
                  inta_n <= 1'b1;
                  cnt    <= 8'd0;
                  state  <= ACK_GAP;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ACK_GAP: begin
               if (cnt != GAP_LAST) begin
                  cnt <= cnt + 8'd1;
               end else if (pulse == last_pulse) begin
                  vec       <= {hi_byte, lo_byte};
                  vec_err   <= err_flag;
                  vec_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  pulse  <= pulse + 2'd1;
                  inta_n <= 1'b0;
                  cnt    <= 8'd0;
                  state  <= ACK_LOW;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
